// File: rtl/pong_pkg.sv
// Shared state encoding, parameter defaults and score helper for the pong controller.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int          DEF_WIN_SCORE    = 7;
    localparam int          DEF_SERVE_FRAMES = 60;
    localparam logic [21:0] DEF_PRESC_INIT   = 22'd250000;

    // Scores stop at 15 rather than wrapping back to zero.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for the debounced start button; a held button yields one press.
module btn_edge (
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic press
);

    logic btn_q;

    always_ff @(posedge CLK) begin
        if (RST) btn_q <= 1'b0;
        else     btn_q <= btn;
    end

    assign press = btn & ~btn_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game flow controller: serve, play, scoring and game over.
// Optional macro SPEED_RAMP_EN: paddle hits shorten the ball step period.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int          WIN_SCORE    = DEF_WIN_SCORE,
    parameter int          SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter logic [21:0] PRESC_INIT   = DEF_PRESC_INIT,
    parameter logic [21:0] PRESC_STEP   = 22'd10000,
    parameter logic [21:0] PRESC_MIN    = 22'd100000,
    parameter logic [9:0]  MISS_L       = 10'd1,
    parameter logic [9:0]  MISS_R       = 10'd638
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        btn_start,
    input  logic        frame_tick,
    input  logic [9:0]  ball_x_l,
    input  logic [9:0]  ball_x_r,
    input  logic        paddle_hit,
    output logic        start,
    output logic        ball_rst,
    output logic [21:0] prescaler,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic        game_over,
    output logic [2:0]  state_o
);

    localparam logic [15:0] SERVE_LAST = 16'(SERVE_FRAMES - 1);
    localparam logic [3:0]  WIN4       = 4'(WIN_SCORE);

    state_t      state;
    logic [15:0] serve_cnt;
    logic        press;
    logic        miss_left;
    logic        miss_right;

    btn_edge u_btn_edge (
        .CLK   (CLK),
        .RST   (RST),
        .btn   (btn_start),
        .press (press)
    );

    assign miss_left  = (ball_x_l <= MISS_L);
    assign miss_right = (ball_x_r >= MISS_R);
    assign state_o    = state;

`ifdef SPEED_RAMP_EN
    logic [22:0] ramp_floor;
    logic [21:0] presc_next;
    // Widened compare so PRESC_MIN + PRESC_STEP cannot overflow the 22-bit range.
    assign ramp_floor = {1'b0, PRESC_MIN} + {1'b0, PRESC_STEP};
    assign presc_next = ({1'b0, prescaler} >= ramp_floor) ? (prescaler - PRESC_STEP) : PRESC_MIN;
`else
    logic unused_ramp;
    assign unused_ramp = paddle_hit ^ (|PRESC_STEP) ^ (|PRESC_MIN);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            start     <= 1'b0;
            ball_rst  <= 1'b1;
            prescaler <= PRESC_INIT;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            game_over <= 1'b0;
            serve_cnt <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press) begin
                        state     <= ST_SERVE;
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        serve_cnt <= 16'd0;
                    end
                end
                ST_SERVE: begin
                    prescaler <= PRESC_INIT;
                    if (frame_tick) begin
                        if (serve_cnt == SERVE_LAST) begin
                            state    <= ST_PLAY;
                            start    <= 1'b1;
                            ball_rst <= 1'b0;
                        end else begin
                            serve_cnt <= serve_cnt + 16'd1;
                        end
                    end
                end
                ST_PLAY: begin
                    // Left miss wins a tie with a simultaneous right miss.
                    if (miss_left) begin
                        score_r  <= sat_inc(score_r);
                        state    <= ST_POINT;
                        start    <= 1'b0;
                        ball_rst <= 1'b1;
                    end else if (miss_right) begin
                        score_l  <= sat_inc(score_l);
                        state    <= ST_POINT;
                        start    <= 1'b0;
                        ball_rst <= 1'b1;
                    end
`ifdef SPEED_RAMP_EN
                    else if (paddle_hit) begin
                        prescaler <= presc_next;
                    end
`endif
                end
                ST_POINT: begin
                    if (score_l == WIN4 || score_r == WIN4) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state     <= ST_SERVE;
                        serve_cnt <= 16'd0;
                    end
                end
                ST_OVER: begin
                    if (press) begin
                        state     <= ST_SERVE;
                        game_over <= 1'b0;
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        serve_cnt <= 16'd0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    start    <= 1'b0;
                    ball_rst <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl against a score/rule model kept in the bench.
module tb_pong_game_ctrl;

    localparam int          WIN   = 7;
    localparam int          NSERV = 60;
    localparam logic [21:0] PINIT = 22'd250000;
    localparam int          PSTEP = 10000;
    localparam int          PMIN  = 100000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        btn_start = 1'b0;
    logic        frame_tick = 1'b0;
    logic [9:0]  ball_x_l = 10'd100;
    logic [9:0]  ball_x_r = 10'd110;
    logic        paddle_hit = 1'b0;
    logic        start;
    logic        ball_rst;
    logic [21:0] prescaler;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic        game_over;
    logic [2:0]  state_o;

    int tests_run = 0;
    int tests_failed = 0;
    int m_l = 0;
    int m_r = 0;

    pong_game_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .btn_start  (btn_start),
        .frame_tick (frame_tick),
        .ball_x_l   (ball_x_l),
        .ball_x_r   (ball_x_r),
        .paddle_hit (paddle_hit),
        .start      (start),
        .ball_rst   (ball_rst),
        .prescaler  (prescaler),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .state_o    (state_o)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_noise(input int n);
        for (int k = 0; k < n; k++) begin
            paddle_hit = 1'($urandom_range(0, 1));
            step();
        end
        paddle_hit = 1'b0;
    endtask

    task automatic press_btn();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
    endtask

    // Feed frame ticks until PLAY, bounded so a stuck serve cannot hang the run.
    task automatic go_play();
        int n = 0;
        while (state_o !== 3'd2 && n < NSERV + 20) begin
            idle_noise($urandom_range(0, 2));
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            n++;
        end
        tests_run++;
        if (state_o !== 3'd2) begin
            tests_failed++;
            $display("FAIL go_play: state=%0d after %0d ticks, required 2", state_o, n);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        step();
        tests_run++;
        if (state_o !== 3'd0 || ball_rst !== 1'b1 || start !== 1'b0 || score_l !== 4'd0 ||
            score_r !== 4'd0 || prescaler !== PINIT || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: state=%0d ball_rst=%b start=%b sl=%0d sr=%0d presc=%0d go=%b",
                     state_o, ball_rst, start, score_l, score_r, prescaler, game_over);
        end
    endtask

    task automatic test_serve();
        bit early = 0;
        btn_start = 1'b1;
        step();
        tests_run++;
        if (state_o !== 3'd1 || ball_rst !== 1'b1 || start !== 1'b0) begin
            tests_failed++;
            $display("FAIL serve_entry: state=%0d ball_rst=%b start=%b, required 1/1/0",
                     state_o, ball_rst, start);
        end
        btn_start = 1'b0;
        m_l = 0;
        m_r = 0;
        for (int i = 1; i <= NSERV; i++) begin
            idle_noise($urandom_range(0, 3));
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (i < NSERV && (start !== 1'b0 || state_o !== 3'd1)) early = 1;
        end
        tests_run++;
        if (early) begin
            tests_failed++;
            $display("FAIL serve_early: start rose before tick %0d", NSERV);
        end
        tests_run++;
        if (start !== 1'b1 || state_o !== 3'd2 || ball_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL serve_release: state=%0d start=%b ball_rst=%b, required 2/1/0",
                     state_o, start, ball_rst);
        end
        tests_run++;
        if (prescaler !== PINIT) begin
            tests_failed++;
            $display("FAIL serve_presc: prescaler=%0d required %0d", prescaler, PINIT);
        end
    endtask

    task automatic test_left_miss();
        ball_x_l = 10'd0;
        step();
        ball_x_l = 10'd100;
        m_r++;
        tests_run++;
        if (state_o !== 3'd3 || score_r !== 4'(m_r) || start !== 1'b0) begin
            tests_failed++;
            $display("FAIL left_miss: state=%0d sr=%0d start=%b, required 3/%0d/0",
                     state_o, score_r, start, m_r);
        end
        step();
        tests_run++;
        if (state_o !== 3'd1 || ball_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL left_miss_serve: state=%0d ball_rst=%b, required 1/1", state_o, ball_rst);
        end
    endtask

    task automatic test_both_miss();
        go_play();
        ball_x_l = 10'd1;
        ball_x_r = 10'd700;
        step();
        ball_x_l = 10'd100;
        ball_x_r = 10'd110;
        m_r++;
        tests_run++;
        if (score_r !== 4'(m_r) || score_l !== 4'(m_l)) begin
            tests_failed++;
            $display("FAIL both_miss: sl=%0d sr=%0d, required %0d/%0d", score_l, score_r, m_l, m_r);
        end
        step();
    endtask

    task automatic test_win_over();
        for (int i = 0; i < WIN; i++) begin
            go_play();
            if (i == WIN - 1) btn_start = 1'b1;
            ball_x_r = 10'd639;
            step();
            ball_x_r = 10'd110;
            m_l++;
            step();
        end
        tests_run++;
        if (score_l !== 4'(WIN) || state_o !== 3'd4 || game_over !== 1'b1 || start !== 1'b0 ||
            ball_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL win_over: sl=%0d state=%0d go=%b start=%b ball_rst=%b",
                     score_l, state_o, game_over, start, ball_rst);
        end
        idle_noise(10);
        tests_run++;
        if (state_o !== 3'd4 || score_l !== 4'(WIN)) begin
            tests_failed++;
            $display("FAIL held_btn: state=%0d sl=%0d, required 4/%0d", state_o, score_l, WIN);
        end
        btn_start = 1'b0;
        step();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        m_l = 0;
        m_r = 0;
        tests_run++;
        if (state_o !== 3'd1 || score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart: state=%0d sl=%0d sr=%0d go=%b, required 1/0/0/0",
                     state_o, score_l, score_r, game_over);
        end
    endtask

    function automatic int presc_model(input int hits);
`ifdef SPEED_RAMP_EN
        int v = int'(PINIT) - hits * PSTEP;
        return (v < PMIN) ? PMIN : v;
`else
        return int'(PINIT) + 0 * hits;
`endif
    endfunction

    task automatic test_prescaler();
        go_play();
        for (int h = 1; h <= 20; h++) begin
            repeat ($urandom_range(0, 2)) step();
            paddle_hit = 1'b1;
            step();
            paddle_hit = 1'b0;
            if (h == 1 || h == 15 || h == 20) begin
                tests_run++;
                if (prescaler !== 22'(presc_model(h))) begin
                    tests_failed++;
                    $display("FAIL presc_hit%0d: prescaler=%0d required %0d",
                             h, prescaler, presc_model(h));
                end
            end
        end
        test_left_miss();
        step();
        tests_run++;
        if (prescaler !== PINIT) begin
            tests_failed++;
            $display("FAIL presc_rally_reset: prescaler=%0d required %0d", prescaler, PINIT);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            go_play();
            ball_x_r = 10'd638;
            step();
            ball_x_r = 10'd110;
            m_l++;
            step();
        end
        go_play();
        tests_run++;
        if (score_l !== 4'd3) begin
            tests_failed++;
            $display("FAIL mid_reset_pre: sl=%0d required 3", score_l);
        end
        RST = 1'b1;
        ball_x_l = 10'd0;
        step();
        RST = 1'b0;
        ball_x_l = 10'd100;
        tests_run++;
        if (state_o !== 3'd0 || score_l !== 4'd0 || score_r !== 4'd0 || start !== 1'b0 ||
            ball_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset: state=%0d sl=%0d sr=%0d start=%b ball_rst=%b",
                     state_o, score_l, score_r, start, ball_rst);
        end
    endtask

    task automatic test_random_games();
        int kind;
        press_btn();
        m_l = 0;
        m_r = 0;
        for (int p = 0; p < 30; p++) begin
            go_play();
            repeat ($urandom_range(0, 4)) begin
                ball_x_l = 10'($urandom_range(2, 600));
                ball_x_r = 10'($urandom_range(2, 637));
                frame_tick = 1'($urandom_range(0, 1));
                step();
            end
            frame_tick = 1'b0;
            tests_run++;
            if (state_o !== 3'd2 || score_l !== 4'(m_l) || score_r !== 4'(m_r)) begin
                tests_failed++;
                $display("FAIL rand_rally%0d: state=%0d sl=%0d sr=%0d, required 2/%0d/%0d",
                         p, state_o, score_l, score_r, m_l, m_r);
            end
            kind = $urandom_range(0, 2);
            ball_x_l = (kind != 1) ? 10'($urandom_range(0, 1)) : 10'd300;
            ball_x_r = (kind != 0) ? 10'($urandom_range(638, 1023)) : 10'd310;
            step();
            ball_x_l = 10'd100;
            ball_x_r = 10'd110;
            if (kind == 1) m_l++;
            else m_r++;
            tests_run++;
            if (state_o !== 3'd3 || score_l !== 4'(m_l) || score_r !== 4'(m_r)) begin
                tests_failed++;
                $display("FAIL rand_point%0d: state=%0d sl=%0d sr=%0d, required 3/%0d/%0d",
                         p, state_o, score_l, score_r, m_l, m_r);
            end
            step();
            if (m_l == WIN || m_r == WIN) begin
                tests_run++;
                if (state_o !== 3'd4 || game_over !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rand_over%0d: state=%0d go=%b, required 4/1", p, state_o, game_over);
                end
                press_btn();
                m_l = 0;
                m_r = 0;
            end else begin
                tests_run++;
                if (state_o !== 3'd1 || game_over !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL rand_serve%0d: state=%0d go=%b, required 1/0", p, state_o, game_over);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_left_miss();
        test_both_miss();
        test_win_over();
        test_prescaler();
        test_mid_reset();
        test_random_games();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7: points needed to win a game (range 1..15).
REQ-002 Parameter SERVE_FRAMES, default 60: frame_tick pulses spent in SERVE before the ball is released.
REQ-003 Parameter PRESC_INIT, default 22'd250000: ball prescaler value at the start of every rally.
REQ-004 Parameter PRESC_STEP, default 22'd10000; parameter PRESC_MIN, default 22'd100000 (used only with SPEED_RAMP_EN).
REQ-005 Parameter MISS_L, default 10'd1; parameter MISS_R, default 10'd638: ball-edge x positions that count as a miss.
REQ-006 CLK  in  1  system/pixel clock; all logic is clocked on its rising edge.
REQ-007 RST  in  1  reset, synchronous to CLK, active-high.
REQ-008 btn_start  in  1  start/restart button, level, already debounced.
REQ-009 frame_tick  in  1  one-CLK pulse once per video frame.
REQ-010 ball_x_l  in  10  current ball left x.
REQ-011 ball_x_r  in  10  current ball right x.
REQ-012 paddle_hit  in  1  one-CLK pulse per paddle bounce.
REQ-013 start  out  1  ball motion enable.
REQ-014 ball_rst  out  1  holds the ball at its serve position while high.
REQ-015 prescaler  out  22  ball step period in CLK cycles.
REQ-016 score_l, score_r  out  4 each  left/right player score.
REQ-017 game_over  out  1  high while a winner is displayed.
REQ-018 state_o  out  3  current FSM state, for debug and overlay.

Function
REQ-019 The FSM SHALL have exactly these states: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-020 btn_start SHALL be rising-edge detected against a one-cycle registered copy; "press" means a detected edge.
REQ-021 IDLE: press -> SERVE, with scores cleared and the serve counter cleared.
REQ-022 SERVE: ball_rst=1, start=0, prescaler=PRESC_INIT; count frame_tick; on the tick that makes the count SERVE_FRAMES -> PLAY.
REQ-023 PLAY: ball_rst=0, start=1.
REQ-024 In PLAY, ball_x_l<=MISS_L SHALL increment score_r and move to POINT in the same edge.
REQ-025 In PLAY, ball_x_r>=MISS_R SHALL increment score_l and move to POINT in the same edge.
REQ-026 If both miss conditions hold in the same cycle, only the left miss (score_r) SHALL count.
REQ-027 POINT SHALL last exactly one cycle with start=0: if either score equals WIN_SCORE -> OVER, else -> SERVE with the serve counter cleared.
REQ-028 OVER: game_over=1, start=0, ball_rst=1, scores held; press -> SERVE with scores cleared.
REQ-029 Scores SHALL saturate at 15 and never wrap.
REQ-030 Outputs start, ball_rst and game_over SHALL be registered, i.e. valid on the cycle in which state_o shows the new state.
REQ-031 frame_tick and paddle_hit SHALL be ignored in every state that does not use them.
REQ-032 A held btn_start SHALL produce at most one press.

Reset
REQ-033 While RST=1, on each CLK edge: state=IDLE, start=0, ball_rst=1, prescaler=PRESC_INIT, score_l=score_r=0, game_over=0, counters=0, edge register=0.
REQ-034 RST asserted mid-rally SHALL abandon the rally, with no score change surviving the reset.
REQ-035 RST SHALL take priority over every other input.

Configuration
REQ-036 With SPEED_RAMP_EN defined, each paddle_hit in PLAY SHALL decrease prescaler by PRESC_STEP, clamped at PRESC_MIN, and never underflow.
REQ-037 Without SPEED_RAMP_EN, prescaler SHALL stay constant at PRESC_INIT and paddle_hit SHALL be unused.

Structure
REQ-038 The state encoding and the defaults for PRESC_INIT, SERVE_FRAMES and WIN_SCORE SHALL live in a shared package, pong_pkg.
REQ-039 The button edge detector SHALL be a sub-module named btn_edge; everything else is a single FSM plus counters.

Verification
REQ-040 RST for 2 cycles, then release -> state_o=0, ball_rst=1, start=0, scores 0, prescaler=250000.
REQ-041 Press in IDLE, then 60 frame_ticks -> start rises on the edge after the 60th tick, and not before.
REQ-042 In PLAY, drive ball_x_l=0 -> score_r=1, one cycle in POINT, then SERVE with ball_rst=1.
REQ-043 Drive 7 right misses (ball_x_r=639) -> score_l=7, state OVER, game_over=1; hold btn_start high -> no restart; release and press again -> SERVE, scores 0.
REQ-044 With SPEED_RAMP_EN, 20 paddle_hits -> prescaler is 240000 after 1 hit and 100000 after 15 hits, staying 100000 afterwards; without the macro it stays 250000.
REQ-045 Assert RST during PLAY with score_l=3 -> next cycle IDLE, score_l=0, start=0.
